xgmii_rx_checker: RTL and testbench



---
 rtl/xgmii_rx_checker.sv | 216 +++++++++++++++++++++
 tb/tb_xgmii_rx_checker.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/xgmii_rx_checker.sv
// XGMII RX frame checker: frame delineation, preamble/SFD, length and control-character checks, saturating stats.
// Define XGMII_RX_CRC_EN to add the FCS check (CRC-32 residue); results always appear 2 cycles after the end word.
module xgmii_rx_checker #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic        xgmii_clk,
    input  logic        sys_rst,
    input  logic [63:0] xgmii_rxd,
    input  logic [7:0]  xgmii_rxc,
    input  logic        link_up,
    input  logic        stat_clr,
    output logic        frame_done,
    output logic        frame_good,
    output logic [15:0] frame_len,
    output logic [31:0] cnt_good,
    output logic [31:0] cnt_bad,
    output logic [31:0] cnt_bytes
);
    localparam logic [7:0]  C_START = 8'hFB;
    localparam logic [7:0]  C_TERM  = 8'hFD;
    localparam logic [7:0]  PRE     = 8'h55;
    localparam logic [7:0]  SFD     = 8'hD5;
    localparam logic [15:0] MIN_L   = 16'(MIN_LEN);
    localparam logic [15:0] MAX_L   = 16'(MAX_LEN);

    typedef enum logic [1:0] {IDLE, PRE_HI, DATA} state_t;

    state_t      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic        err_q, err_d;
    logic        ev_q, ev_d, ev_bad_q, ev_bad_d;
    logic [15:0] ev_len_q, ev_len_d;

    logic        start0, start4, pre0_ok, pre4_ok, prehi_ok;
    logic        ctl_any, restart, good_s1, fcs_ok;
    logic [2:0]  ctl_lane;
    logic [7:0]  ctl_char;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [3:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {13'd0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    // Start/preamble decode of the current word, usable from IDLE and from an FB abort.
    always_comb begin
        start0   = xgmii_rxc[0] && (xgmii_rxd[7:0] == C_START);
        start4   = xgmii_rxc[4] && (xgmii_rxd[39:32] == C_START);
        pre0_ok  = (xgmii_rxc[7:1] == 7'd0) && (xgmii_rxd[63:8] == {SFD, {6{PRE}}});
        pre4_ok  = (xgmii_rxc[7:5] == 3'd0) && (xgmii_rxd[63:40] == {3{PRE}});
        prehi_ok = (xgmii_rxc == 8'd0) && (xgmii_rxd[31:0] == {SFD, {3{PRE}}});
    end

    // NOTE: every variable written in an always_comb gets a default first, so no latch is inferred.
    always_comb begin
        ctl_any  = 1'b0;
        ctl_lane = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (xgmii_rxc[i]) begin
                ctl_any  = 1'b1;
                ctl_lane = 3'(i);
            end
        end
        ctl_char = xgmii_rxd[{ctl_lane, 3'b000} +: 8];
    end

    // Frame FSM: the first control character in DATA ends the frame; anything but FD makes it bad.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        err_d    = err_q;
        ev_d     = 1'b0;
        ev_bad_d = 1'b0;
        ev_len_d = len_q;
        restart  = 1'b0;
        case (state_q)
            IDLE: restart = 1'b1;
            PRE_HI: begin
                len_d   = 16'd4;
                err_d   = err_q | ~prehi_ok;
                state_d = DATA;
            end
            DATA: begin
                if (!ctl_any) begin
                    len_d = sat_add16(len_q, 4'd8);
                end else begin
                    ev_d     = 1'b1;
                    ev_len_d = sat_add16(len_q, {1'b0, ctl_lane});
                    ev_bad_d = err_q | (ctl_char != C_TERM);
                    state_d  = IDLE;
                    restart  = (ctl_char == C_START);
                end
            end
            default: state_d = IDLE;
        endcase
        if (restart) begin
            if (start0) begin
                state_d = DATA;
                len_d   = 16'd0;
                err_d   = ~pre0_ok;
            end else if (start4) begin
                state_d = PRE_HI;
                len_d   = 16'd0;
                err_d   = ~pre4_ok;
            end
        end
        if (!link_up) begin
            state_d = IDLE;
            ev_d    = 1'b0;
        end
    end

`ifdef XGMII_RX_CRC_EN
    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

    logic [31:0] crc_q, crc_d, crc_w, ev_crc_q;
    logic [7:0]  data_mask;

    function automatic logic [31:0] crc_lanes(input logic [31:0] c_in, input logic [63:0] d,
                                              input logic [7:0] en);
        logic [31:0] c;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            if (en[i]) begin
                for (int b = 0; b < 8; b++)
                    c = (c >> 1) ^ (CRC_POLY & {32{c[0] ^ d[8*i+b]}});
            end
        end
        return c;
    endfunction

    always_comb begin
        for (int i = 0; i < 8; i++)
            data_mask[i] = !ctl_any || (3'(i) < ctl_lane);
        crc_w = crc_lanes(crc_q, xgmii_rxd, data_mask);
        crc_d = CRC_INIT;
        case (state_q)
            PRE_HI:  crc_d = crc_lanes(CRC_INIT, xgmii_rxd, 8'hF0);
            DATA:    crc_d = ctl_any ? CRC_INIT : crc_w;
            default: crc_d = CRC_INIT;
        endcase
    end

    always_ff @(posedge xgmii_clk) begin
        if (sys_rst) begin
            crc_q    <= CRC_INIT;
            ev_crc_q <= CRC_INIT;
        end else begin
            crc_q    <= crc_d;
            ev_crc_q <= crc_w;
        end
    end

    assign fcs_ok = (ev_crc_q == CRC_RESIDUE);
`else
    assign fcs_ok = 1'b1;
`endif

    assign good_s1 = !ev_bad_q && (ev_len_q >= MIN_L) && (ev_len_q <= MAX_L) && fcs_ok;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge xgmii_clk) begin
        if (sys_rst) begin
            state_q  <= IDLE;
            len_q    <= 16'd0;
            err_q    <= 1'b0;
            ev_q     <= 1'b0;
            ev_bad_q <= 1'b0;
            ev_len_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            err_q    <= err_d;
            ev_q     <= ev_d;
            ev_bad_q <= ev_bad_d;
            ev_len_q <= ev_len_d;
        end
    end

    // Result stage; counters move on the same edge so they already include the frame flagged by frame_done.
    always_ff @(posedge xgmii_clk) begin
        if (sys_rst) begin
            frame_done <= 1'b0;
            frame_good <= 1'b0;
            frame_len  <= 16'd0;
            cnt_good   <= 32'd0;
            cnt_bad    <= 32'd0;
            cnt_bytes  <= 32'd0;
        end else begin
            frame_done <= ev_q;
            frame_good <= ev_q && good_s1;
            frame_len  <= ev_q ? ev_len_q : 16'd0;
            if (stat_clr) begin
                cnt_good  <= 32'd0;
                cnt_bad   <= 32'd0;
                cnt_bytes <= 32'd0;
            end else if (ev_q) begin
                if (good_s1) begin
                    cnt_good  <= sat_add32(cnt_good, 32'd1);
                    cnt_bytes <= sat_add32(cnt_bytes, {16'd0, ev_len_q});
                end else begin
                    cnt_bad   <= sat_add32(cnt_bad, 32'd1);
                end
            end
        end
    end
endmodule

// File: tb/tb_xgmii_rx_checker.sv
// Bench for xgmii_rx_checker: builds frames as lane/byte streams, predicts results from frame contents.
module tb_xgmii_rx_checker;
    localparam int MIN_LEN = 64;
    localparam int MAX_LEN = 1518;
    localparam logic [8:0] IDL = 9'h107;
`ifdef XGMII_RX_CRC_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif

    logic        xgmii_clk = 1'b0;
    logic        sys_rst, link_up, stat_clr;
    logic [63:0] rxd;
    logic [7:0]  rxc;
    logic        frame_done, frame_good;
    logic [15:0] frame_len;
    logic [31:0] cnt_good, cnt_bad, cnt_bytes;

    xgmii_rx_checker #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
        .xgmii_clk (xgmii_clk),
        .sys_rst   (sys_rst),
        .xgmii_rxd (rxd),
        .xgmii_rxc (rxc),
        .link_up   (link_up),
        .stat_clr  (stat_clr),
        .frame_done(frame_done),
        .frame_good(frame_good),
        .frame_len (frame_len),
        .cnt_good  (cnt_good),
        .cnt_bad   (cnt_bad),
        .cnt_bytes (cnt_bytes)
    );

    always #3 xgmii_clk = ~xgmii_clk;

    typedef struct { int term_pos; bit good; int len; } exp_t;
    typedef struct { int cyc; bit good; int len; logic [31:0] cg, cb, cby; } obs_t;

    logic [7:0] fr[$];
    logic [8:0] strm[$];
    exp_t       pend[$];
    obs_t       obs[$];
    obs_t       mon;
    int         cyc = 0;
    int         drop_word = -1;
    int         checks = 0, errors = 0;
    longint     m_good = 0, m_bad = 0, m_bytes = 0;

    always @(posedge xgmii_clk) cyc <= cyc + 1;

    always @(negedge xgmii_clk) begin
        if (frame_done) begin
            mon.cyc  = cyc;
            mon.good = frame_good;
            mon.len  = int'(frame_len);
            mon.cg   = cnt_good;
            mon.cb   = cnt_bad;
            mon.cby  = cnt_bytes;
            obs.push_back(mon);
        end
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Standard Ethernet FCS over fr[0..n-1].
    function automatic logic [31:0] crc_of(input int n);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++)
            for (int b = 0; b < 8; b++)
                c = (c[0] ^ fr[i][b]) ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        return ~c;
    endfunction

    // Appends one frame (start, preamble, bytes, FD) to the stream and records the expected result.
    task automatic put_frame(input int len, input bit lane4, input int flip_bit, input int err_at,
                             input int abort_at, input bit bad_sfd, input bit expect_it);
        logic [31:0] fcs;
        bit          crc_ok;
        exp_t        e;
        fr.delete();
        for (int i = 0; i < len - 4; i++) fr.push_back(8'($urandom));
        fcs = crc_of(len - 4);
        for (int i = 0; i < 4; i++) fr.push_back(fcs[8*i +: 8]);
        if (flip_bit >= 0) fr[flip_bit / 8] = fr[flip_bit / 8] ^ (8'd1 << (flip_bit % 8));
        crc_ok = (crc_of(len - 4) == {fr[len-1], fr[len-2], fr[len-3], fr[len-4]});
        while (strm.size() % 8 != 0) strm.push_back(IDL);
        if (lane4) repeat (4) strm.push_back(IDL);
        strm.push_back(9'h1FB);
        repeat (6) strm.push_back(9'h055);
        strm.push_back(bad_sfd ? 9'h0D4 : 9'h0D5);
        e.term_pos = -1;
        for (int i = 0; i < len; i++) begin
            if (i == abort_at) begin
                e.term_pos = strm.size();
                break;
            end
            if (i == err_at) begin
                e.term_pos = strm.size();
                strm.push_back(9'h1FE);
            end else begin
                strm.push_back({1'b0, fr[i]});
            end
        end
        if (e.term_pos < 0) e.term_pos = strm.size();
        if (abort_at < 0) strm.push_back(9'h1FD);
        if (abort_at >= 0)    e.len = abort_at;
        else if (err_at >= 0) e.len = err_at;
        else                  e.len = len;
        e.good = (abort_at < 0) && (err_at < 0) && !bad_sfd && (len >= MIN_LEN) && (len <= MAX_LEN)
                 && (crc_ok || !CRC_EN);
        if (expect_it) pend.push_back(e);
    endtask

    // Drives the stream word by word, then compares the frame_done events against the expectations.
    task automatic flush(input int tail, input bit clr);
        int   c0, nw, clr_cyc;
        exp_t e;
        obs_t o;
        c0 = 0;
        clr_cyc = -1;
        while (strm.size() % 8 != 0) strm.push_back(IDL);
        repeat (tail * 8) strm.push_back(IDL);
        nw = strm.size() / 8;
        obs.delete();
        for (int w = 0; w < nw; w++) begin
            @(negedge xgmii_clk);
            if (w == 0) begin
                c0 = cyc;
                if (clr && pend.size() > 0) clr_cyc = c0 + pend[0].term_pos / 8 + 2;
            end
            link_up  = (w != drop_word);
            stat_clr = (cyc == clr_cyc);
            for (int l = 0; l < 8; l++) begin
                rxd[8*l +: 8] = strm[8*w+l][7:0];
                rxc[l]        = strm[8*w+l][8];
            end
        end
        @(negedge xgmii_clk);
        link_up  = 1'b1;
        stat_clr = 1'b0;
        #1;
        check("n_events", obs.size(), pend.size());
        for (int i = 0; i < pend.size() && i < obs.size(); i++) begin
            e = pend[i];
            o = obs[i];
            check("done_cycle", o.cyc, c0 + e.term_pos / 8 + 2);
            check("frame_good", o.good, e.good);
            check("frame_len", o.len, e.len);
            if (e.good) begin
                if (m_good < 64'hFFFF_FFFF) m_good++;
                m_bytes = (m_bytes + e.len > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_bytes + e.len;
            end else if (m_bad < 64'hFFFF_FFFF) begin
                m_bad++;
            end
            check("cnt_good", o.cg, m_good);
            check("cnt_bad", o.cb, m_bad);
            check("cnt_bytes", o.cby, m_bytes);
        end
        if (clr) begin
            m_good = 0;
            m_bad = 0;
            m_bytes = 0;
        end
        check("cnt_good_after", cnt_good, m_good);
        check("cnt_bad_after", cnt_bad, m_bad);
        check("cnt_bytes_after", cnt_bytes, m_bytes);
        pend.delete();
        strm.delete();
        drop_word = -1;
    endtask

    initial begin
        sys_rst  = 1'b1;
        link_up  = 1'b1;
        stat_clr = 1'b0;
        rxd      = {8{8'h07}};
        rxc      = 8'hFF;
        repeat (4) @(negedge xgmii_clk);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_frame_good", frame_good, 1'b0);
        check("rst_frame_len", frame_len, 16'd0);
        check("rst_cnt_good", cnt_good, 32'd0);
        check("rst_cnt_bad", cnt_bad, 32'd0);
        check("rst_cnt_bytes", cnt_bytes, 32'd0);
        sys_rst = 1'b0;
        repeat (2) @(negedge xgmii_clk);

        // Minimum-size good frame, lane-0 start, FD alone in lane 0.
        put_frame(64, 1'b0, -1, -1, -1, 1'b0, 1'b1);
        flush(3, 1'b0);

        // Maximum and one-over-maximum with lane-4 starts.
        put_frame(1518, 1'b1, -1, -1, -1, 1'b0, 1'b1);
        put_frame(1519, 1'b1, -1, -1, -1, 1'b0, 1'b1);
        flush(3, 1'b0);

        // Runt, FE in lane 3 of word 5, FE inside a legal-length frame, bad SFD.
        put_frame(60, 1'b0, -1, -1, -1, 1'b0, 1'b1);
        put_frame(100, 1'b0, -1, 35, -1, 1'b0, 1'b1);
        put_frame(100, 1'b0, -1, 75, -1, 1'b0, 1'b1);
        put_frame(80, 1'b0, -1, -1, -1, 1'b1, 1'b1);
        flush(3, 1'b0);

        // Payload bit flip: only the FCS check can reject it.
        put_frame(64, 1'b0, 8 * 20 + 3, -1, -1, 1'b0, 1'b1);
        flush(3, 1'b0);

        // FB abort mid-frame restarts directly into a new frame.
        put_frame(100, 1'b0, -1, -1, 40, 1'b0, 1'b1);
        put_frame(70, 1'b0, -1, -1, -1, 1'b0, 1'b1);
        flush(3, 1'b0);

        // Link drop for one word discards the frame; the following frame is received.
        drop_word = 3;
        put_frame(120, 1'b0, -1, -1, -1, 1'b0, 1'b0);
        put_frame(64, 1'b1, -1, -1, -1, 1'b0, 1'b1);
        flush(3, 1'b0);

        // Random back-to-back frames, mixed start lanes and lengths around MIN_LEN.
        for (int f = 0; f < 8; f++)
            put_frame(int'($urandom_range(48, 240)), 1'($urandom_range(0, 1)), -1, -1, -1, 1'b0, 1'b1);
        flush(3, 1'b0);

        // Good-frame counter saturation.
        @(negedge xgmii_clk);
        force dut.cnt_good = 32'hFFFF_FFFE;
        @(negedge xgmii_clk);
        release dut.cnt_good;
        m_good = 64'hFFFF_FFFE;
        #1;
        check("cnt_good_preset", cnt_good, 32'hFFFF_FFFE);
        repeat (3) put_frame(64, 1'b0, -1, -1, -1, 1'b0, 1'b1);
        flush(3, 1'b0);

        // stat_clr while frame_done is high: everything reads zero afterwards.
        put_frame(64, 1'b0, -1, -1, -1, 1'b0, 1'b1);
        flush(3, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
